datapath_scheduler: RTL and testbench

Shares one polynomial datapath and its `bloco_controle` sequencer among `N_REQ` requesters. Requests are arbitrated round-robin. The winner's operand is forwarded, the controller's `start` is pulsed, and the scheduler waits for the controller's `valid`. The result is then returned to the winning requester, tagged by a one-hot `done`. A watchdog aborts transactions that never complete. The block sits between the requester ports and the controller/datapath pair.

---
 rtl/datapath_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_datapath_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : datapath_scheduler                                           |
// | Description : Round-robin scheduler that shares one polynomial datapath    |
// |               and its sequencer among N_REQ requesters, with a watchdog    |
// |               that aborts transactions the controller never completes.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module datapath_scheduler #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   x_in,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          done,
    output logic [DATA_W-1:0]         result,
    output logic                      err,
    output logic                      busy,
    input  logic                      dp_ready,
    input  logic                      dp_valid,
    input  logic [DATA_W-1:0]         dp_result,
    output logic                      dp_start,
    output logic [DATA_W-1:0]         dp_x
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_RESP  = 2'd3;

    // Last WAIT cycle index before abort, and the saturation ceiling of the timer.
    localparam logic [TMR_W-1:0] c_TMR_LAST = TMR_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [TMR_W-1:0] c_TMR_MAX  = {TMR_W{1'b1}};
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(N_REQ - 1);

    // Registered state and outputs
    logic [1:0]        r_state_q;
    logic [IDX_W-1:0]  r_idx_q;
    logic [IDX_W-1:0]  r_ptr_q;
    logic [TMR_W-1:0]  r_timer_q;
    logic [DATA_W-1:0] r_dp_x_q;
    logic [DATA_W-1:0] r_result_q;
    logic              r_err_q;
    logic              r_busy_q;
    logic              r_start_q;
    logic [N_REQ-1:0]  r_gnt_q;
    logic [N_REQ-1:0]  r_done_q;

    // Next-state values
    logic [1:0]        w_state_d;
    logic [IDX_W-1:0]  w_idx_d;
    logic [IDX_W-1:0]  w_ptr_d;
    logic [TMR_W-1:0]  w_timer_d;
    logic [DATA_W-1:0] w_dp_x_d;
    logic [DATA_W-1:0] w_result_d;
    logic              w_err_d;
    logic              w_busy_d;
    logic              w_start_d;
    logic [N_REQ-1:0]  w_gnt_d;
    logic [N_REQ-1:0]  w_done_d;

    // Arbitration results
    logic              w_found;
    logic [IDX_W-1:0]  w_win;
    logic [IDX_W-1:0]  w_cand;
    int                w_sum;
    logic [DATA_W-1:0] w_opnd;
    logic              w_expired;

    // Round-robin search: first set request scanning from the pointer upward, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        w_sum   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = int'(r_ptr_q) + k;
            if (w_sum >= N_REQ) begin
                w_sum = w_sum - N_REQ;
            end
            w_cand = IDX_W'(w_sum);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    // Operand mux for the winning requester's lane.
    always_comb begin
        w_opnd = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win == IDX_W'(i)) begin
                w_opnd = x_in[i*DATA_W +: DATA_W];
            end
        end
    end

    // Watchdog expiry; a zero TIMEOUT never expires.
    assign w_expired = (TIMEOUT != 0) && (r_timer_q == c_TMR_LAST);

    // Next-state logic; pulse outputs are computed one cycle ahead so they leave flops.
    always_comb begin
        w_state_d  = r_state_q;
        w_idx_d    = r_idx_q;
        w_ptr_d    = r_ptr_q;
        w_timer_d  = r_timer_q;
        w_dp_x_d   = r_dp_x_q;
        w_result_d = r_result_q;
        w_err_d    = 1'b0;
        w_start_d  = 1'b0;
        w_gnt_d    = '0;
        w_done_d   = '0;
        case (r_state_q)
            c_ST_IDLE: begin
                if (dp_ready && w_found) begin
                    w_state_d      = c_ST_ISSUE;
                    w_idx_d        = w_win;
                    w_dp_x_d       = w_opnd;
                    w_start_d      = 1'b1;
                    w_gnt_d[w_win] = 1'b1;
                end
            end
            c_ST_ISSUE: begin
                w_timer_d = '0;
                w_state_d = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                // A completion in the expiry cycle takes priority over the abort.
                if (dp_valid) begin
                    w_result_d        = dp_result;
                    w_err_d           = 1'b0;
                    w_done_d[r_idx_q] = 1'b1;
                    w_state_d         = c_ST_RESP;
                end else if (w_expired) begin
                    w_result_d        = '0;
                    w_err_d           = 1'b1;
                    w_done_d[r_idx_q] = 1'b1;
                    w_state_d         = c_ST_RESP;
                end else if (r_timer_q != c_TMR_MAX) begin
                    w_timer_d = r_timer_q + 1'b1;
                end
            end
            c_ST_RESP: begin
                w_ptr_d   = (r_idx_q == c_IDX_LAST) ? '0 : (r_idx_q + 1'b1);
                w_state_d = c_ST_IDLE;
            end
            default: begin
                w_state_d = c_ST_IDLE;
            end
        endcase
        w_busy_d = (w_state_d != c_ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q  <= c_ST_IDLE;
            r_idx_q    <= '0;
            r_ptr_q    <= '0;
            r_timer_q  <= '0;
            r_dp_x_q   <= '0;
            r_result_q <= '0;
            r_err_q    <= 1'b0;
            r_busy_q   <= 1'b0;
            r_start_q  <= 1'b0;
            r_gnt_q    <= '0;
            r_done_q   <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_idx_q    <= w_idx_d;
            r_ptr_q    <= w_ptr_d;
            r_timer_q  <= w_timer_d;
            r_dp_x_q   <= w_dp_x_d;
            r_result_q <= w_result_d;
            r_err_q    <= w_err_d;
            r_busy_q   <= w_busy_d;
            r_start_q  <= w_start_d;
            r_gnt_q    <= w_gnt_d;
            r_done_q   <= w_done_d;
        end
    end

    assign gnt      = r_gnt_q;
    assign done     = r_done_q;
    assign result   = r_result_q;
    assign err      = r_err_q;
    assign busy     = r_busy_q;
    assign dp_start = r_start_q;
    assign dp_x     = r_dp_x_q;

endmodule
`default_nettype wire

// File: tb/tb_datapath_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_datapath_scheduler                                        |
// | Description : Self-checking bench for datapath_scheduler: directed vector  |
// |               table, reset-in-WAIT sequence, and randomized transactions   |
// |               checked against a transaction-level round-robin model.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_datapath_scheduler;

    localparam int N_REQ   = 4;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 8;

    logic                    clock = 1'b0;
    logic                    reset;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] x_in;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        done;
    logic [DATA_W-1:0]       result;
    logic                    err;
    logic                    busy;
    logic                    dp_ready;
    logic                    dp_valid;
    logic [DATA_W-1:0]       dp_result;
    logic                    dp_start;
    logic [DATA_W-1:0]       dp_x;

    int n_checks = 0;
    int n_errors = 0;

    datapath_scheduler #(
        .N_REQ   (N_REQ),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .x_in      (x_in),
        .gnt       (gnt),
        .done      (done),
        .result    (result),
        .err       (err),
        .busy      (busy),
        .dp_ready  (dp_ready),
        .dp_valid  (dp_valid),
        .dp_result (dp_result),
        .dp_start  (dp_start),
        .dp_x      (dp_x)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          do_reset;
        logic [3:0]  req;
        logic [63:0] xs;
        int          lat;       // WAIT cycle carrying dp_valid; > TIMEOUT means never
        int          rd;        // cycles of dp_ready=0 before the selection cycle
        logic [15:0] res;
        int          exp_win;
        logic [15:0] exp_res;
        bit          exp_err;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        req      = '0;
        dp_ready = 1'b0;
        dp_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // One full transaction from IDLE back to IDLE with expected winner/result/err supplied.
    task automatic txn(input logic [3:0] req_v, input logic [63:0] xs, input int lat,
                       input int rd, input bit jitter, input logic [15:0] res_v,
                       input int exp_win, input logic [15:0] exp_res, input bit exp_err);
        logic [3:0]  oh;
        logic [15:0] ex;
        int          nw;
        oh   = 4'b0001 << exp_win;
        ex   = xs[exp_win*16 +: 16];
        nw   = (lat <= TIMEOUT) ? lat : TIMEOUT;
        x_in = xs;
        dp_ready = 1'b0;
        for (int c = 0; c < rd; c++) begin
            req       = jitter ? 4'($urandom) : req_v;
            dp_valid  = 1'($urandom);
            dp_result = 16'($urandom);
            tick();
            check("gated_gnt", 64'(gnt), 64'd0);
            check("gated_start", 64'(dp_start), 64'd0);
            check("gated_busy", 64'(busy), 64'd0);
        end
        req       = req_v;
        dp_ready  = 1'b1;
        dp_valid  = 1'($urandom);
        dp_result = 16'($urandom);
        tick();
        check("issue_gnt", 64'(gnt), 64'(oh));
        check("issue_start", 64'(dp_start), 64'd1);
        check("issue_dp_x", 64'(dp_x), 64'(ex));
        check("issue_busy", 64'(busy), 64'd1);
        check("issue_done", 64'(done), 64'd0);
        req      = 4'($urandom);
        x_in     = {$urandom, $urandom};
        dp_ready = 1'b0;
        dp_valid = 1'($urandom);   // must be ignored during ISSUE
        tick();
        check("wait_start", 64'(dp_start), 64'd0);
        check("wait_gnt", 64'(gnt), 64'd0);
        for (int c = 1; c <= nw; c++) begin
            dp_valid  = (c == lat);
            dp_result = (c == lat) ? res_v : 16'($urandom);
            tick();
            if (c < nw) begin
                check("wait_done", 64'(done), 64'd0);
                check("wait_dp_x", 64'(dp_x), 64'(ex));
            end else begin
                check("resp_done", 64'(done), 64'(oh));
                check("resp_result", 64'(result), 64'(exp_res));
                check("resp_err", 64'(err), 64'(exp_err));
                check("resp_busy", 64'(busy), 64'd1);
            end
        end
        dp_valid = 1'($urandom);
        req      = '0;
        dp_ready = 1'b0;
        tick();
        check("idle_done", 64'(done), 64'd0);
        check("idle_err", 64'(err), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_result_hold", 64'(result), 64'(exp_res));
    endtask

    // Reference arbiter: first set request bit scanning from ptr, modulo N_REQ.
    function automatic int model_pick(input int ptr, input logic [3:0] r);
        for (int k = 0; k < N_REQ; k++) begin
            if (r[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
        end
        return -1;
    endfunction

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          model_ptr;
        logic [3:0]  rv;
        logic [63:0] xs;
        logic [15:0] rr;
        int          lat;
        int          w;

        // Single request, full contention, pointer wrap, timeout, valid-at-expiry, ready gating
        tbl[0]  = '{0, 4'b0001, 64'h4444_3333_2222_0005, 6,  0,  16'd31,   0, 16'd31,   0};
        tbl[1]  = '{1, 4'b1111, 64'hA003_A002_A001_A000, 3,  0,  16'h1111, 0, 16'h1111, 0};
        tbl[2]  = '{0, 4'b1111, 64'hB003_B002_B001_B000, 1,  0,  16'h2222, 1, 16'h2222, 0};
        tbl[3]  = '{0, 4'b1111, 64'hC003_C002_C001_C000, 2,  0,  16'h3333, 2, 16'h3333, 0};
        tbl[4]  = '{0, 4'b1111, 64'hD003_D002_D001_D000, 4,  0,  16'h4444, 3, 16'h4444, 0};
        tbl[5]  = '{0, 4'b1111, 64'hE003_E002_E001_E000, 5,  0,  16'h5555, 0, 16'h5555, 0};
        tbl[6]  = '{0, 4'b0010, 64'h0000_0000_0F0F_0000, 2,  0,  16'h6666, 1, 16'h6666, 0};
        tbl[7]  = '{0, 4'b1010, 64'h7773_0000_7771_0000, 3,  0,  16'h7777, 3, 16'h7777, 0};
        tbl[8]  = '{0, 4'b1010, 64'h8883_0000_8881_0000, 2,  0,  16'h8888, 1, 16'h8888, 0};
        tbl[9]  = '{0, 4'b0001, 64'h0000_0000_0000_9990, 13, 0,  16'h9999, 0, 16'h0000, 1};
        tbl[10] = '{0, 4'b0001, 64'h0000_0000_0000_ABC0, 8,  0,  16'hBEEF, 0, 16'hBEEF, 0};
        tbl[11] = '{0, 4'b0100, 64'h0000_0C0C_0000_0000, 3,  10, 16'hCAFE, 2, 16'hCAFE, 0};

        reset     = 1'b1;
        req       = '0;
        x_in      = '0;
        dp_ready  = 1'b0;
        dp_valid  = 1'b0;
        dp_result = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_start", 64'(dp_start), 64'd0);
        check("rst_dp_x", 64'(dp_x), 64'd0);

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].do_reset) do_reset();
            txn(tbl[i].req, tbl[i].xs, tbl[i].lat, tbl[i].rd, 1'b0, tbl[i].res,
                tbl[i].exp_win, tbl[i].exp_res, tbl[i].exp_err);
        end

        // Reset asserted while waiting on the controller
        req      = 4'b0100;
        x_in     = 64'h1234_5678_9ABC_DEF0;
        dp_ready = 1'b1;
        dp_valid = 1'b0;
        tick();
        check("mid_gnt", 64'(gnt), 64'h4);
        dp_ready = 1'b0;
        tick();
        tick();
        check("mid_busy_wait", 64'(busy), 64'd1);
        reset = 1'b1;
        req   = '0;
        tick();
        reset = 1'b0;
        check("mid_rst_gnt", 64'(gnt), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_result", 64'(result), 64'd0);
        check("mid_rst_err", 64'(err), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_start", 64'(dp_start), 64'd0);
        check("mid_rst_dp_x", 64'(dp_x), 64'd0);
        txn(4'b0011, 64'h0000_0000_0202_0101, 3, 0, 1'b0, 16'h0303, 0, 16'h0303, 1'b0);
        model_ptr = 1;

        // Randomized transactions against the round-robin model
        for (int n = 0; n < 40; n++) begin
            rv  = 4'($urandom_range(1, 15));
            xs  = {$urandom, $urandom};
            rr  = 16'($urandom);
            lat = $urandom_range(1, TIMEOUT + 2);
            w   = model_pick(model_ptr, rv);
            txn(rv, xs, lat, $urandom_range(0, 3), 1'b1, rr, w,
                (lat <= TIMEOUT) ? rr : 16'h0000, (lat > TIMEOUT));
            model_ptr = (w + 1) % N_REQ;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
